cmd_pack_tx: RTL and testbench
==============================

// Module: cmd_pack_tx
// PURPOSE
//  Upstream end of the command SPI link: serialises one command frame (sync, length, payload, CRC-16) onto spi_sclk/spi_dout
//  for the depack receiver on the sweep-control board. Used by the board-level test fixture and by the loop-back self-test
//  path to generate frames. Single clock domain; spi_sclk is a divided copy of clk.
// PARAMETERS
//  PAYLOAD_BYTES  43   payload length in bytes, 1..255; also sent as the LEN byte
//  CLK_DIV        4    clk cycles per spi_sclk half-period, >=2
//  GAP_CYCLES     64   idle clk cycles after the last bit, before ready re-asserts (frame separation, no CS line)
// PORTS
//  clk            in   1                 system clock
//  rst            in   1                 asynchronous reset, active-high
//  load           in   1                 one-cycle request; accepted only when ready=1
//  payload        in   8*PAYLOAD_BYTES   byte 0 = payload[8*PAYLOAD_BYTES-1 -: 8], sent first
//  ready          out  1                 idle, able to accept load
//  done           out  1                 one-cycle pulse at end of the gap
//  spi_sclk       out  1                 serial clock, idle low
//  spi_dout       out  1                 serial data, MSB first, changes on falling sclk edge
//  inject_crc_err in   1                 (CRC_ERR_INJ_EN only) latched with load
// BEHAVIOUR
//  - Reset (async): ready=1, done=0, spi_sclk=0, spi_dout=0, state IDLE, all counters/shift regs cleared.
//  - Frame: SYNC 16'hEB90 | LEN 8'(PAYLOAD_BYTES) | payload bytes 0..N-1 | CRC16 (MSB first). Bits = 40 + 8*N.
//  - CRC: CRC-16/CCITT-FALSE, poly 0x1021, init 0xFFFF, no reflection, no final xor; covers payload bytes only,
//    computed bit-serially as payload bits are shifted out; final CRC register frozen before the CRC field is sent.
//  - FSM IDLE -> SHIFT -> GAP -> IDLE.
//    IDLE: load&ready at edge t -> payload latched; at t+1 ready=0, state SHIFT, spi_dout = first bit (1), spi_sclk=0.
//    SHIFT: spi_sclk toggles every CLK_DIV clks; rises CLK_DIV clks after each bit is driven; next bit driven on the
//      falling edge. After the falling edge following the last bit: spi_dout=0, spi_sclk stays 0, state GAP.
//    GAP: counts GAP_CYCLES clks; on the last one done=1 for one cycle and ready=1 in that same cycle; state IDLE.
//  - Bit period 2*CLK_DIV clks; total load-to-done = 1 + 2*CLK_DIV*(40+8*N) + GAP_CYCLES clks.
//  - load while ready=0 ignored (no queueing); payload changes after acceptance have no effect on the frame in flight.
//  - load in the same cycle done pulses: ignored (ready was 0 on that edge); accepted on the next cycle.
//  - Reset mid-frame: outputs return to reset values immediately; truncated frame is discarded by the receiver's sync
//    search; no done pulse.
// CONFIGURATION
//  - CRC_ERR_INJ_EN defined: port inject_crc_err present; when latched 1 at load the transmitted CRC has bit 0 inverted
//    (payload and timing unchanged) to exercise receiver crc_err.
//  - Not defined: port absent, CRC always correct.
// STRUCTURE
//  - Package cmd_link_pkg: SYNC_WORD=16'hEB90, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF, field widths/byte offsets of the
//    command payload (ftw, sweep step/rate, periods, mode, att, pha), shared with depack.
//  - Sub-module crc16_ccitt_ser: 1-bit-per-enable CRC update (clk, rst, clr, en, din, crc[15:0]).
//  - Top level: FSM, sclk divider counter, bit counter (width clog2(40+8*255)), frame shift register, gap counter.
// TESTING
//  - N=9, payload "123456789" (0x31..0x39): captured frame = EB90 09 31..39 29B1, 112 rising sclk edges, done once.
//  - N=43, CLK_DIV=4, GAP=64: load->done exactly 1+8*384+64 = 3137 clks; ready low throughout, high with done.
//  - load pulsed every cycle during a frame: exactly one frame sent; second frame starts 1 cycle after done.
//  - rst asserted at bit 50: spi_sclk/spi_dout=0, ready=1 same cycle; next load sends a complete, correct frame.
//  - CRC_ERR_INJ_EN, "123456789", inject_crc_err=1: CRC field 29B0; with depack in loop, crc_err=1 and ready not set.
//  - Loop-back into depack with random payloads (100 frames): every depack field equals the sent field, crc_err=0.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared definitions for the command SPI link (cmd_pack_tx / depack):
// framing constants, CRC-16/CCITT-FALSE parameters, FSM state type and
// the field layout of the 43-byte command payload.
package cmd_link_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hEB90;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  // Frame = SYNC(16) | LEN(8) | payload(8*N) | CRC(16)
  localparam int unsigned HDR_BITS          = 24;
  localparam int unsigned CRC_BITS          = 16;
  localparam int unsigned MAX_PAYLOAD_BYTES = 255;
  localparam int unsigned BIT_CNT_W =
    $clog2(HDR_BITS + CRC_BITS + 8 * MAX_PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } tx_state_t;

  // Command payload layout (byte offsets from payload byte 0, widths in bits)
  localparam int unsigned CMD_PAYLOAD_BYTES   = 43;
  localparam int unsigned FTW_START_OFS       = 0;
  localparam int unsigned FTW_START_W         = 48;
  localparam int unsigned FTW_STOP_OFS        = 6;
  localparam int unsigned FTW_STOP_W          = 48;
  localparam int unsigned SWEEP_STEP_OFS      = 12;
  localparam int unsigned SWEEP_STEP_W        = 48;
  localparam int unsigned SWEEP_RATE_OFS      = 18;
  localparam int unsigned SWEEP_RATE_W        = 32;
  localparam int unsigned PERIOD_DWELL_OFS    = 22;
  localparam int unsigned PERIOD_DWELL_W      = 32;
  localparam int unsigned PERIOD_SETTLE_OFS   = 26;
  localparam int unsigned PERIOD_SETTLE_W     = 32;
  localparam int unsigned MODE_OFS            = 30;
  localparam int unsigned MODE_W              = 8;
  localparam int unsigned ATT_OFS             = 31;
  localparam int unsigned ATT_W               = 16;
  localparam int unsigned PHA_OFS             = 33;
  localparam int unsigned PHA_W               = 16;
  localparam int unsigned RSVD_OFS            = 35;
  localparam int unsigned RSVD_W              = 64;

  // Packed view of the payload; first declared field is transmitted first
  typedef struct packed {
    logic [FTW_START_W-1:0]     ftw_start;
    logic [FTW_STOP_W-1:0]      ftw_stop;
    logic [SWEEP_STEP_W-1:0]    sweep_step;
    logic [SWEEP_RATE_W-1:0]    sweep_rate;
    logic [PERIOD_DWELL_W-1:0]  period_dwell;
    logic [PERIOD_SETTLE_W-1:0] period_settle;
    logic [MODE_W-1:0]          mode;
    logic [ATT_W-1:0]           att;
    logic [PHA_W-1:0]           pha;
    logic [RSVD_W-1:0]          rsvd;
  } cmd_payload_t;

  // One-bit CRC-16/CCITT-FALSE step (MSB-first, no reflection)
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic        din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_ccitt_ser.sv
// Bit-serial CRC-16/CCITT-FALSE: one message bit folded in per enable.
// clr preloads CRC_INIT; reset clears the register.
module crc16_ccitt_ser
  import cmd_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC register: clear-to-init takes priority over an update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/cmd_pack_tx.sv
// cmd_pack_tx: serialises one command frame (SYNC, LEN, payload, CRC-16)
// onto spi_sclk/spi_dout, MSB first, data changing on falling sclk.
// Optional build macro CRC_ERR_INJ_EN adds inject_crc_err, which flips
// bit 0 of the transmitted CRC for the frame it is latched with.
module cmd_pack_tx
  import cmd_link_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 43,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       ready,
  output logic                       done,
  output logic                       spi_sclk,
  output logic                       spi_dout
`ifdef CRC_ERR_INJ_EN
  ,
  input  logic                       inject_crc_err
`endif
);

  localparam int unsigned DATA_BITS  = HDR_BITS + 8 * PAYLOAD_BYTES;
  localparam int unsigned FRAME_BITS = DATA_BITS + CRC_BITS;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] PAY_FIRST = BIT_CNT_W'(HDR_BITS);
  localparam logic [BIT_CNT_W-1:0] CRC_FIRST = BIT_CNT_W'(DATA_BITS);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  tx_state_t              state;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  // Bits still to send after the one on spi_dout (the bit on the wire is not kept)
  logic [DATA_BITS-2:0]   data_sr;
  logic [15:0]            crc_sr;
  logic                   inj_q;

  logic [DATA_BITS-1:0]   frame_data;
  logic                   accept;
  logic                   sclk_fall;
  logic [BIT_CNT_W-1:0]   next_bit;
  logic                   crc_en;
  logic                   crc_din;
  logic [15:0]            crc_val;
  logic [15:0]            crc_word;

  assign frame_data = {SYNC_WORD, 8'(PAYLOAD_BYTES), payload};

  // Handshake, falling-edge detection and CRC feed for the bit about to be driven
  always_comb begin
    accept    = load && ready;
    sclk_fall = (state == ST_SHIFT) && (div_cnt == DIV_LAST) && spi_sclk;
    next_bit  = bit_cnt + 1'b1;
    // Payload bits are folded into the CRC as they go onto the wire, so the
    // register is final by the time the first CRC bit is needed.
    crc_en    = sclk_fall && (bit_cnt != LAST_BIT) &&
                (next_bit >= PAY_FIRST) && (next_bit < CRC_FIRST);
    crc_din   = data_sr[DATA_BITS-2];
    crc_word  = crc_val ^ {15'b0, inj_q};
  end

  crc16_ccitt_ser u_crc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_val)
  );

`ifdef CRC_ERR_INJ_EN
  // Error-injection request captured with the frame it applies to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= inject_crc_err;
    end
  end
`else
  assign inj_q = 1'b0;
`endif

  // Frame FSM: sclk divider, bit/gap counters, shift registers, registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_dout <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      data_sr  <= '0;
      crc_sr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SHIFT;
            ready    <= 1'b0;
            spi_sclk <= 1'b0;
            spi_dout <= frame_data[DATA_BITS-1];
            data_sr  <= frame_data[DATA_BITS-2:0];
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_sclk <= ~spi_sclk;
            if (spi_sclk) begin
              if (bit_cnt == LAST_BIT) begin
                spi_dout <= 1'b0;
                gap_cnt  <= '0;
                state    <= ST_GAP;
              end else begin
                bit_cnt <= next_bit;
                if (next_bit < CRC_FIRST) begin
                  spi_dout <= data_sr[DATA_BITS-2];
                  data_sr  <= {data_sr[DATA_BITS-3:0], 1'b0};
                end else if (next_bit == CRC_FIRST) begin
                  spi_dout <= crc_word[15];
                  crc_sr   <= {crc_word[14:0], 1'b0};
                end else begin
                  spi_dout <= crc_sr[15];
                  crc_sr   <= {crc_sr[14:0], 1'b0};
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            done  <= 1'b1;
            ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_pack_tx.sv
// Self-checking bench for cmd_pack_tx: known CRC vector, load-to-done
// timing, load spamming, mid-frame reset and random payload frames.
module tb_cmd_pack_tx;

  localparam int unsigned N          = 9;
  localparam int unsigned CD         = 3;
  localparam int unsigned GAP        = 10;
  localparam int unsigned FRAME_BITS = 40 + 8 * N;
  localparam int unsigned FRAME_CLKS = 1 + 2 * CD * FRAME_BITS + GAP;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [8*N-1:0]   payload;
  logic             ready;
  logic             done;
  logic             spi_sclk;
  logic             spi_dout;
  logic             inj = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit   cap[$];
  logic sclk_prev = 1'b0;

  always #5 clk = ~clk;

  cmd_pack_tx #(
    .PAYLOAD_BYTES (N),
    .CLK_DIV       (CD),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .payload  (payload),
    .ready    (ready),
    .done     (done),
    .spi_sclk (spi_sclk),
    .spi_dout (spi_dout)
`ifdef CRC_ERR_INJ_EN
    ,
    .inject_crc_err (inj)
`endif
  );

  // Receiver model: capture spi_dout on every rising spi_sclk
  always @(negedge clk) begin
    if (spi_sclk && !sclk_prev) cap.push_back(spi_dout);
    sclk_prev <= spi_sclk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input byte_q_t b);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic byte_q_t ref_frame(input byte_q_t b, input bit flip);
    byte_q_t f;
    logic [15:0] c;
    c = ref_crc(b) ^ {15'b0, flip};
    f.push_back(8'hEB);
    f.push_back(8'h90);
    f.push_back(8'(N));
    foreach (b[i]) f.push_back(b[i]);
    f.push_back(c[15:8]);
    f.push_back(c[7:0]);
    return f;
  endfunction

  function automatic logic [7:0] cap_byte(input int unsigned i);
    logic [7:0] v = 8'h00;
    for (int unsigned j = 0; j < 8; j++)
      v = {v[6:0], (8*i + j < cap.size()) ? cap[8*i + j] : 1'bx};
    return v;
  endfunction

  function automatic byte_q_t rand_bytes();
    byte_q_t b;
    for (int unsigned i = 0; i < N; i++) b.push_back(8'($urandom_range(0, 255)));
    return b;
  endfunction

  task automatic drive_payload(input byte_q_t b);
    for (int unsigned i = 0; i < N; i++) payload[8*N-1-8*i -: 8] = b[i];
  endtask

  // One frame: load, wait (bounded) for done, compare timing and captured bytes
  task automatic run_frame(input string tag, input byte_q_t b, input bit flip,
                           input bit keep_load);
    byte_q_t     exp;
    int unsigned cycles;
    bit          got_done;
    bit          ready_bad;
    exp = ref_frame(b, flip);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    cap.delete();
    drive_payload(b);
    inj       = flip;
    load      = 1'b1;
    cycles    = 0;
    got_done  = 1'b0;
    ready_bad = 1'b0;
    while (cycles < 2 * FRAME_CLKS && !got_done) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        check({tag, "_accept_ready"}, 32'(ready), 32'd0);
        check({tag, "_accept_done"}, 32'(done), 32'd0);
        if (!keep_load) load = 1'b0;
        drive_payload(rand_bytes());
        inj = ~flip;
      end
      if (done) got_done = 1'b1;
      else if (ready) ready_bad = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_load_to_done"}, cycles, FRAME_CLKS);
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({tag, "_ready_with_done"}, 32'(ready), 32'd1);
    check({tag, "_rise_count"}, cap.size(), FRAME_BITS);
    for (int unsigned i = 0; i < N + 5; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_byte(i)), 32'(exp[i]));
    if (!keep_load) begin
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    byte_q_t     vec;
    int unsigned k;
    rst     = 1'b1;
    load    = 1'b0;
    payload = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_dout", 32'(spi_dout), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known vector "123456789" -> CRC 29B1
    for (int unsigned i = 0; i < N; i++) vec.push_back(8'h31 + 8'(i));
    run_frame("vec", vec, 1'b0, 1'b0);
    check("vec_crc_hi", 32'(cap_byte(N + 3)), 32'h29);
    check("vec_crc_lo", 32'(cap_byte(N + 4)), 32'hB1);
`ifdef CRC_ERR_INJ_EN
    run_frame("inj", vec, 1'b1, 1'b0);
    check("inj_crc_lo", 32'(cap_byte(N + 4)), 32'hB0);
`endif

    // load held high across a frame: one frame, next accepted right after done
    run_frame("spam1", rand_bytes(), 1'b0, 1'b1);
    run_frame("spam2", rand_bytes(), 1'b0, 1'b0);

    // Reset around bit 50 of a frame
    @(negedge clk);
    drive_payload(rand_bytes());
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    k = 0;
    while (cap.size() < 50 && k < 2 * FRAME_CLKS) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("mid_reached_bit50", 32'(cap.size() >= 50), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
    check("mid_rst_dout", 32'(spi_dout), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", rand_bytes(), 1'b0, 1'b0);

    // Random payloads
    for (int unsigned f = 0; f < 12; f++)
      run_frame($sformatf("rnd%0d", f), rand_bytes(), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
